// File: rtl/ras_stack.sv
// Return address stack for fetch1, fed by the BTB's ras_ctl prediction.
//
// Optional feature macro: RAS_TOS_REPAIR_EN
//   When defined, adds ras_ckpt_tos_o / flush_tos_i so a redirect also rewrites
//   the checkpointed top entry, undoing wrong-path push or pop-then-push damage.
//
// Ports:
//   clock, reset        core clock; synchronous active-high reset
//   ras_valid_i         bundle valid with BTB hit, qualifies ras_ctl_i
//   ras_ctl_i           00 none, 01 push, 10 pop, 11 pop-then-push
//   push_addr_i         return address to push (bits [1:0] dropped)
//   ras_tos_o           top-of-stack address, 0 when empty
//   ras_empty_o         occupancy is zero
//   ras_underflow_o     one-cycle pulse after a pop on an empty stack
//   ras_ckpt_ptr_o      current TOS pointer, carried with the bundle
//   ras_ckpt_cnt_o      current occupancy, carried with the bundle
//   flush_i             redirect: restore flush_ptr_i / flush_cnt_i
//   ras_ckpt_tos_o      (RAS_TOS_REPAIR_EN) copy of ras_tos_o for checkpointing
//   flush_tos_i         (RAS_TOS_REPAIR_EN) top entry value to restore on flush
module ras_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ras_valid_i,
  input  logic [1:0]    ras_ctl_i,
  input  logic [63:0]   push_addr_i,
  output logic [63:0]   ras_tos_o,
  output logic          ras_empty_o,
  output logic          ras_underflow_o,
  output logic [PW-1:0] ras_ckpt_ptr_o,
  output logic [PW:0]   ras_ckpt_cnt_o,
  input  logic          flush_i,
  input  logic [PW-1:0] flush_ptr_i,
  input  logic [PW:0]   flush_cnt_i
`ifdef RAS_TOS_REPAIR_EN
  ,
  output logic [63:0]   ras_ckpt_tos_o,
  input  logic [63:0]   flush_tos_i
`endif
);

  localparam logic [1:0]    CtlNone    = 2'b00;
  localparam logic [1:0]    CtlPush    = 2'b01;
  localparam logic [1:0]    CtlPop     = 2'b10;
  localparam logic [1:0]    CtlPopPush = 2'b11;
  localparam logic [PW-1:0] PtrReset   = PW'(DEPTH - 1);
  localparam logic [PW:0]   CntMax     = (PW + 1)'(DEPTH);

  logic [61:0]   mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          underflow_q, underflow_d;

  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [61:0]   wr_data;

  // Only the word address is stored; the low bits are always zero.
  logic unused_addr_lsbs;
`ifdef RAS_TOS_REPAIR_EN
  assign unused_addr_lsbs = ^{push_addr_i[1:0], flush_tos_i[1:0]};
`else
  assign unused_addr_lsbs = ^push_addr_i[1:0];
`endif

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    wr_data     = push_addr_i[63:2];

    if (flush_i) begin
      // Redirect wins over any same-cycle operation from the (wrong-path) bundle.
      ptr_d = flush_ptr_i;
      cnt_d = (flush_cnt_i > CntMax) ? CntMax : flush_cnt_i;
`ifdef RAS_TOS_REPAIR_EN
      wr_en   = 1'b1;
      wr_idx  = flush_ptr_i;
      wr_data = flush_tos_i[63:2];
`endif
    end else if (ras_valid_i) begin
      unique case (ras_ctl_i)
        CtlNone: ;
        CtlPush: begin
          // PW == log2(DEPTH), so pointer arithmetic wraps modulo DEPTH for free.
          ptr_d  = ptr_q + 1'b1;
          wr_en  = 1'b1;
          wr_idx = ptr_q + 1'b1;
          // A push on a full stack silently overwrites the oldest entry.
          cnt_d  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
        CtlPop: begin
          if (cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        CtlPopPush: begin
          // Replace the top entry in place; an empty stack gains one entry.
          wr_en  = 1'b1;
          wr_idx = ptr_q;
          if (cnt_q == '0) cnt_d = (PW + 1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q       <= PtrReset;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign ras_empty_o     = (cnt_q == '0);
  assign ras_tos_o       = ras_empty_o ? 64'h0 : {mem_q[ptr_q], 2'b00};
  assign ras_underflow_o = underflow_q;
  assign ras_ckpt_ptr_o  = ptr_q;
  assign ras_ckpt_cnt_o  = cnt_q;
`ifdef RAS_TOS_REPAIR_EN
  assign ras_ckpt_tos_o  = ras_tos_o;
`endif

endmodule

// File: tb/tb_ras_stack.sv
module tb_ras_stack;

  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ras_valid_i = 1'b0;
  logic [1:0]    ras_ctl_i = 2'b00;
  logic [63:0]   push_addr_i = '0;
  logic [63:0]   ras_tos_o;
  logic          ras_empty_o;
  logic          ras_underflow_o;
  logic [PW-1:0] ras_ckpt_ptr_o;
  logic [PW:0]   ras_ckpt_cnt_o;
  logic          flush_i = 1'b0;
  logic [PW-1:0] flush_ptr_i = '0;
  logic [PW:0]   flush_cnt_i = '0;
`ifdef RAS_TOS_REPAIR_EN
  logic [63:0]   ras_ckpt_tos_o;
  logic [63:0]   flush_tos_i = '0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ras_stack #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clock           (clock),
    .reset           (reset),
    .ras_valid_i     (ras_valid_i),
    .ras_ctl_i       (ras_ctl_i),
    .push_addr_i     (push_addr_i),
    .ras_tos_o       (ras_tos_o),
    .ras_empty_o     (ras_empty_o),
    .ras_underflow_o (ras_underflow_o),
    .ras_ckpt_ptr_o  (ras_ckpt_ptr_o),
    .ras_ckpt_cnt_o  (ras_ckpt_cnt_o),
    .flush_i         (flush_i),
    .flush_ptr_i     (flush_ptr_i),
`ifdef RAS_TOS_REPAIR_EN
    .flush_cnt_i     (flush_cnt_i),
    .ras_ckpt_tos_o  (ras_ckpt_tos_o),
    .flush_tos_i     (flush_tos_i)
`else
    .flush_cnt_i     (flush_cnt_i)
`endif
  );

  // Reference model: circular array of full addresses, pointer and count as integers.
  logic [63:0] m_mem [DEPTH];
  int          m_ptr;
  int          m_cnt;
  bit          m_uf;

  function automatic logic [63:0] m_tos();
    if (m_cnt == 0) return 64'h0;
    return m_mem[m_ptr];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = DEPTH - 1;
    m_cnt = 0;
    m_uf  = 0;
  endtask

  task automatic m_update(input bit v, input int c, input logic [63:0] a, input bit f,
                          input int fp, input int fc, input logic [63:0] ft);
    m_uf = 0;
    if (f) begin
      m_ptr = fp;
      m_cnt = (fc > DEPTH) ? DEPTH : fc;
`ifdef RAS_TOS_REPAIR_EN
      m_mem[fp] = {ft[63:2], 2'b00};
`endif
    end else if (v) begin
      if (c == 1) begin
        m_ptr = (m_ptr + 1) % DEPTH;
        m_mem[m_ptr] = {a[63:2], 2'b00};
        if (m_cnt < DEPTH) m_cnt++;
      end else if (c == 2) begin
        if (m_cnt > 0) begin
          m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
          m_cnt--;
        end else begin
          m_uf = 1;
        end
      end else if (c == 3) begin
        m_mem[m_ptr] = {a[63:2], 2'b00};
        if (m_cnt == 0) m_cnt = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tos"}, ras_tos_o, m_tos());
    chk({tag, ".empty"}, 64'(ras_empty_o), 64'(m_cnt == 0));
    chk({tag, ".uf"}, 64'(ras_underflow_o), 64'(m_uf));
    chk({tag, ".ptr"}, 64'(ras_ckpt_ptr_o), 64'(m_ptr));
    chk({tag, ".cnt"}, 64'(ras_ckpt_cnt_o), 64'(m_cnt));
`ifdef RAS_TOS_REPAIR_EN
    chk({tag, ".ckpt_tos"}, ras_ckpt_tos_o, m_tos());
`endif
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge, outputs are
  // checked at the same point, so operations can run back to back.
  task automatic step(input string tag, input bit v, input int c, input logic [63:0] a,
                      input bit f = 0, input int fp = 0, input int fc = 0,
                      input logic [63:0] ft = 64'h0);
    ras_valid_i = v;
    ras_ctl_i   = 2'(c);
    push_addr_i = a;
    flush_i     = f;
    flush_ptr_i = PW'(fp);
    flush_cnt_i = (PW + 1)'(fc);
`ifdef RAS_TOS_REPAIR_EN
    flush_tos_i = ft;
`endif
    @(posedge clock);
    m_update(v, c, a, f, fp, fc, ft);
    #1;
    ras_valid_i = 0;
    flush_i     = 0;
    check_all(tag);
  endtask

  // Reset held with junk push and flush on the inputs: reset must win.
  task automatic do_reset();
    reset       = 1;
    ras_valid_i = 1;
    ras_ctl_i   = 2'b01;
    push_addr_i = 64'hdead_beef;
    flush_i     = 1;
    flush_ptr_i = 3;
    flush_cnt_i = 5;
    @(posedge clock);
    #1;
    reset       = 0;
    ras_valid_i = 0;
    flush_i     = 0;
    m_reset();
    check_all("reset");
  endtask

  int          ck_ptr, ck_cnt;
  logic [63:0] ck_tos;

  initial begin
    do_reset();
    chk("reset.tos_zero", ras_tos_o, 64'h0);
    chk("reset.ptr_const", 64'(ras_ckpt_ptr_o), 64'(DEPTH - 1));

    // Basic push/pop.
    step("push1", 1, 1, 64'h1000);
    step("push2", 1, 1, 64'h2000);
    chk("basic.tos2", ras_tos_o, 64'h2000);
    chk("basic.cnt2", 64'(ras_ckpt_cnt_o), 64'd2);
    step("pop1", 1, 2, 0);
    chk("basic.tos1", ras_tos_o, 64'h1000);
    step("pop2", 1, 2, 0);
    chk("basic.empty", 64'(ras_empty_o), 64'd1);

    // Underflow pulse lasts one cycle, state untouched.
    step("pop_empty", 1, 2, 0);
    chk("uf.pulse", 64'(ras_underflow_o), 64'd1);
    chk("uf.ptr", 64'(ras_ckpt_ptr_o), 64'(DEPTH - 1));
    step("idle_after_uf", 0, 0, 0);
    chk("uf.cleared", 64'(ras_underflow_o), 64'd0);

    // Overflow wrap: 17 pushes keep the newest 16.
    for (int i = 1; i <= 17; i++) step("wrap_push", 1, 1, 64'(i * 'h100));
    chk("wrap.cnt", 64'(ras_ckpt_cnt_o), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("wrap.pop_tos", ras_tos_o, 64'(32'h1100 - i * 'h100));
      step("wrap_pop", 1, 2, 0);
    end
    chk("wrap.empty", 64'(ras_empty_o), 64'd1);

    // Pop-then-push, including on an empty stack; low address bits dropped.
    do_reset();
    step("pp_push", 1, 1, 64'h4000);
    step("pp_swap", 1, 3, 64'h5003);
    chk("pp.tos", ras_tos_o, 64'h5000);
    chk("pp.cnt", 64'(ras_ckpt_cnt_o), 64'd1);
    step("pp_pop", 1, 2, 0);
    step("pp_empty", 1, 3, 64'h6000);
    chk("pp_empty.cnt", 64'(ras_ckpt_cnt_o), 64'd1);
    chk("pp_empty.uf", 64'(ras_underflow_o), 64'd0);

    // Checkpoint / flush recovery with a same-cycle push ignored.
    do_reset();
    step("ck_a", 1, 1, 64'ha000);
    step("ck_b", 1, 1, 64'hb000);
    step("ck_c", 1, 1, 64'hc000);
    chk("ck.ptr", 64'(ras_ckpt_ptr_o), 64'd2);
    chk("ck.cnt", 64'(ras_ckpt_cnt_o), 64'd3);
    step("wp_pop1", 1, 2, 0);
    step("wp_pop2", 1, 2, 0);
    step("wp_push", 1, 1, 64'h9000);
    step("flush", 1, 1, 64'h8000, 1, 2, 3, 64'hc000);
    chk("flush.tos", ras_tos_o, 64'hc000);
    chk("flush.cnt", 64'(ras_ckpt_cnt_o), 64'd3);
    step("flush_clamp", 0, 0, 0, 1, 5, 31, 64'h0);
    chk("flush_clamp.cnt", 64'(ras_ckpt_cnt_o), 64'd16);

`ifdef RAS_TOS_REPAIR_EN
    do_reset();
    step("rp_push", 1, 1, 64'h3000);
    step("rp_wrong", 1, 3, 64'h7000);
    step("rp_flush", 0, 0, 0, 1, 0, 1, 64'h3000);
    chk("repair.tos", ras_tos_o, 64'h3000);
`endif

    // Random traffic against the model, with checkpoints taken from the model.
    do_reset();
    ck_ptr = m_ptr;
    ck_cnt = m_cnt;
    ck_tos = m_tos();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 31));
      if (r == 0) begin
        step("rnd_flush", 1, int'($urandom_range(0, 3)), {32'h0, $urandom}, 1, ck_ptr,
             ck_cnt, ck_tos);
      end else if (r == 1) begin
        step("rnd_flush_any", 1, 1, {32'h0, $urandom}, 1, int'($urandom_range(0, DEPTH - 1)),
             int'($urandom_range(0, 31)), {$urandom, $urandom});
      end else begin
        step("rnd", $urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
             {$urandom, $urandom});
      end
      if ($urandom_range(0, 7) == 0) begin
        ck_ptr = m_ptr;
        ck_cnt = m_cnt;
        ck_tos = m_tos();
      end
      if (n == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return address stack in fetch1, directly downstream of the BTB way.
- Consumes the BTB's ras_ctl prediction for the hit bundle:
  - pushes return addresses for predicted calls;
  - supplies the predicted target for returns.
- The fetch PC mux uses ras_tos_o instead of the BTB target when the BTB reports a return.
- Checkpoint/restore ports let a redirect (mispredict, exception) repair the speculative stack state.

Parameters:
DEPTH, 16, number of stack entries; power of two, minimum 4
PW, 4, pointer width, equal to log2(DEPTH)

Ports:
clock  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ras_valid_i  in  1  fetch1 bundle valid with BTB hit; qualifies ras_ctl_i
ras_ctl_i  in  2  00 none, 01 push (call), 10 pop (return), 11 pop-then-push (coroutine)
push_addr_i  in  64  return address to push (bundle PC + 4*(brpos+1)); bits [1:0] ignored and stored as 0
ras_tos_o  out  64  current top-of-stack address; 0 when empty
ras_empty_o  out  1  count == 0
ras_underflow_o  out  1  one-cycle pulse: pop requested while empty
ras_ckpt_ptr_o  out  PW  current TOS pointer, carried with the bundle for recovery
ras_ckpt_cnt_o  out  PW+1  current occupancy, carried with the bundle
flush_i  in  1  redirect; restore the checkpoint
flush_ptr_i  in  PW  checkpointed TOS pointer
flush_cnt_i  in  PW+1  checkpointed occupancy

Behaviour:
- Storage:
  - circular array of DEPTH x 62 bits (address[63:2]);
  - tos_ptr indexes the top valid entry;
  - cnt counts 0..DEPTH.
- Reset:
  - tos_ptr = DEPTH-1, cnt = 0, all entries = 0;
  - ras_tos_o = 0, ras_empty_o = 1, ras_underflow_o = 0, ras_ckpt_ptr_o = DEPTH-1, ras_ckpt_cnt_o = 0.
- Outputs:
  - ras_tos_o, ras_empty_o and the checkpoint outputs are combinational from registered state (zero-latency read).
  - A pop in cycle N uses the ras_tos_o value present in cycle N.
  - Operation effects become visible at cycle N+1.
- Push (ras_valid_i & ctl==01):
  - tos_ptr <= tos_ptr+1 (mod DEPTH); entry[tos_ptr+1] <= push_addr_i[63:2];
  - cnt <= min(cnt+1, DEPTH);
  - full push overwrites the oldest entry (wrap); no error is raised.
- Pop (ctl==10), cnt>0: tos_ptr <= tos_ptr-1 (mod DEPTH); cnt <= cnt-1.
- Pop, cnt==0: state unchanged; ras_underflow_o = 1 for the next cycle only.
- Pop-then-push (ctl==11):
  - entry[tos_ptr] <= push_addr_i; tos_ptr unchanged;
  - cnt unchanged if cnt>0; cnt <= 1 if cnt==0;
  - no underflow is raised.
- ras_valid_i=0 or ctl==00: no state change.
- flush_i:
  - tos_ptr <= flush_ptr_i; cnt <= min(flush_cnt_i, DEPTH);
  - overrides any same-cycle push/pop; ras_underflow_o <= 0.
  - Entry contents are not repaired; see the optional feature.
- reset overrides flush_i and all operations.
- Back-to-back operations every cycle are supported with no bubbles.

Optional Feature:
RAS_TOS_REPAIR_EN
- Defined:
  - adds port ras_ckpt_tos_o (out, 64), equal to ras_tos_o;
  - adds port flush_tos_i (in, 64);
  - on flush_i, also writes entry[flush_ptr_i] <= flush_tos_i[63:2].
  - This repairs a top entry corrupted by wrong-path push or pop-then-push.
- Undefined: these ports are absent; flush restores pointer and count only.

Test Plan:
- Reset, then push 0x1000, 0x2000 -> ras_tos_o=0x2000, cnt=2; pop -> next cycle ras_tos_o=0x1000; pop -> ras_empty_o=1, ras_tos_o=0.
- Pop on empty stack -> ras_underflow_o=1 for exactly one cycle; tos_ptr=DEPTH-1 and cnt=0 unchanged.
- Push 17 addresses 0x100..0x1100 (step 0x100) with DEPTH=16 -> cnt=16, ras_tos_o=0x1100; 16 pops return 0x1100 down to 0x200, then ras_empty_o=1.
- Push A=0x4000; ctl=11 with 0x5000 -> ras_tos_o=0x5000, cnt=1; ctl=11 on an empty stack -> cnt=1, no underflow.
- Capture checkpoint (ptr=P, cnt=3); wrong-path pop, pop, push 0x9000; flush_i with same-cycle push -> ptr=P, cnt=3, push ignored.
- With RAS_TOS_REPAIR_EN: checkpoint top=0x3000, wrong-path ctl=11 with 0x7000, flush with flush_tos_i=0x3000 -> ras_tos_o=0x3000 next cycle.
